dmem_window_cache: RTL and testbench
====================================

# dmem_window_cache

Parametrised data-memory window cache that sits between the EX-stage data port and the external memory controller. It holds NUM_WIN independently tagged windows of 2^WIN_AW words each. On a miss it selects a victim round-robin, writes the victim back if it is dirty, and requests a refill. It also adds a software-visible flush of all dirty windows.

## Interface
- ADDR_W, 32, word-address width
- DATA_W, 32, data width
- WIN_AW, 10, word-offset bits per window
- NUM_WIN, 2, number of windows; must be a power of two, ≥1
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- cpu_req  in  1  access request
- cpu_we  in  1  write when 1, read when 0
- cpu_addr  in  ADDR_W  word address
- cpu_wdata  in  DATA_W  write data
- cpu_rdata  out  DATA_W  read data, registered
- cpu_stall  out  1  request not accepted this cycle
- flush_req  in  1  one-cycle pulse: write back and invalidate all windows
- flush_done  out  1  one-cycle pulse when flush completes
- mc_req  out  1  operation pending for the controller
- mc_wb  out  1  1 = write-back, 0 = refill
- mc_base, mc_high  out  ADDR_W  first and last word address of the window being moved
- mc_addr  in  WIN_AW  controller word offset
- mc_we  in  1  controller writes mc_din
- mc_din  in  DATA_W  refill data
- mc_dout  out  DATA_W  write-back data, one cycle after mc_addr
- mc_done  in  1  one-cycle pulse, operation complete

## Operation
- TAG_W = ADDR_W − WIN_AW.
- Each window w holds valid[w], dirty[w] and tag[w].
- Hit: cpu_req is high, valid[w] is set, and tag[w] equals cpu_addr[ADDR_W-1:WIN_AW]. At most one window can match.
- States: IDLE, WB, FILL, UPDATE, FL_SCAN, FL_WB.
- IDLE:
  - cpu_req with a miss: latch the miss tag. Victim = rr_ptr. Go to WB if dirty[victim], else FILL.
  - Otherwise flush_req: idx ← 0, go to FL_SCAN.
  - A miss takes priority over flush_req. A flush_req that loses is held pending and taken on the next eligible IDLE cycle.
- WB: mc_req=1, mc_wb=1, mc_base={tag[victim], WIN_AW'b0}, mc_high={tag[victim], all ones}. On mc_done go to FILL.
- FILL: mc_req=1, mc_wb=0, base and high are built from the latched miss tag. Controller writes go to word {victim, mc_addr}. On mc_done go to UPDATE.
- UPDATE: tag[victim] ← miss tag, valid ← 1, dirty ← 0, rr_ptr ← rr_ptr+1 (wraps modulo NUM_WIN). Return to IDLE. The CPU retry then hits.
- FL_SCAN: if valid[idx] and dirty[idx], set victim=idx and go to FL_WB. Otherwise clear valid[idx]. If idx = NUM_WIN−1, pulse flush_done and go to IDLE; else idx+1.
- FL_WB: the same handshake as WB. On mc_done clear valid[idx] and dirty[idx], then continue the scan as in FL_SCAN.
- An accepted write (cpu_req & cpu_we & !cpu_stall) updates the hit window word and sets dirty for that window.
- mc_we is ignored outside FILL. mc_done is ignored outside WB, FILL and FL_WB.

## Timing
- cpu_stall = cpu_req & (state≠IDLE | miss | flush pending). This is combinational.
- Read latency is 1: cpu_rdata is valid in the cycle after acceptance and holds until the next accepted read.
- The minimum miss penalty for a clean victim is FILL plus the controller time plus 1 UPDATE cycle. The hit is accepted on the cycle after UPDATE.
- mc_req, mc_wb, mc_base and mc_high are registered and stable from state entry until mc_done.
- mc_req drops in the cycle after mc_done.
- flush_req while busy is latched and served on return to IDLE.
- Reset values:
  - mc_req, mc_wb, flush_done, cpu_rdata, mc_base and mc_high are all 0.
  - All valid and dirty bits are 0, rr_ptr=0, state=IDLE.
  - RAM contents are undefined.
- Reset asserted mid-transfer aborts the transfer immediately. No write-back occurs.

## Structure
- Package dmem_win_pkg holds the state enum and the TAG_W/index-width helper functions.
- Sub-module dmem_win_ram is a true dual-port RAM of NUM_WIN·2^WIN_AW words, both ports on rising clk.
  - Port A serves the CPU, addressed by {hit_idx, offset}.
  - Port B serves the controller, addressed by {victim, mc_addr}.

## Test plan
- Cold read of addr 0x0000_0404: stall, FILL with mc_base=0x400 and mc_high=0x7FF. Controller writes 0xDEAD_BEEF at offset 4, mc_done. The read is accepted after UPDATE and cpu_rdata=0xDEAD_BEEF one cycle later.
- Write 0x1234 to 0x404 (hit), then miss 0x800 and miss 0xC00 (NUM_WIN=2). The third miss evicts window 0: WB with mc_base=0x400 first, and mc_dout at offset 4 = 0x1234, then FILL with mc_base=0xC00.
- Clean victim miss: no WB phase; mc_wb stays 0 throughout.
- flush_req with window 1 dirty and window 0 clean: exactly one WB for window 1, then flush_done pulses once and all valid bits are 0.
- Simultaneous cpu_req miss and flush_req: the miss is serviced first, then the flush runs, and the CPU stalls during the flush.
- Reset during FILL: mc_req=0 immediately, and a following read of the same address misses again.

Source files
------------

// File: rtl/dmem_win_pkg.sv
// Shared types and width helpers for the data-memory window cache.
package dmem_win_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WB      = 3'd1,
    ST_FILL    = 3'd2,
    ST_UPDATE  = 3'd3,
    ST_FL_SCAN = 3'd4,
    ST_FL_WB   = 3'd5
  } state_e;

  // Tag width: address bits above the window offset.
  function automatic int unsigned calc_tag_w(input int unsigned addr_w, input int unsigned win_aw);
    return addr_w - win_aw;
  endfunction

  // Window index width; a single window still gets one index bit.
  function automatic int unsigned calc_idx_w(input int unsigned num_win);
    return (num_win > 1) ? $clog2(num_win) : 1;
  endfunction

endpackage

// File: rtl/dmem_win_ram.sv
// True dual-port word RAM: port A for the CPU, port B for the memory controller.
module dmem_win_ram #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned AW     = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_a_en,
  input  logic              i_a_we,
  input  logic [AW-1:0]     i_a_addr,
  input  logic [DATA_W-1:0] i_a_wdata,
  output logic [DATA_W-1:0] o_a_rdata,
  input  logic              i_b_we,
  input  logic [AW-1:0]     i_b_addr,
  input  logic [DATA_W-1:0] i_b_wdata,
  output logic [DATA_W-1:0] o_b_rdata
);

  localparam int unsigned DEPTH = 2 ** AW;

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Array writes; the two ports never write in the same cycle.
  always_ff @(posedge clk) begin
    if (i_a_en && i_a_we) r_mem[i_a_addr] <= i_a_wdata;
    if (i_b_we)           r_mem[i_b_addr] <= i_b_wdata;
  end

  // Port A read data, held until the next accepted read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   o_a_rdata <= '0;
    else if (i_a_en && !i_a_we) o_a_rdata <= r_mem[i_a_addr];
  end

  // Port B read data, one cycle behind the controller address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) o_b_rdata <= '0;
    else      o_b_rdata <= r_mem[i_b_addr];
  end

endmodule

// File: rtl/dmem_window_cache.sv
// Multi-window data cache with round-robin victim choice, write-back and flush.
module dmem_window_cache
  import dmem_win_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned WIN_AW  = 10,
  parameter int unsigned NUM_WIN = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              flush_req,
  output logic              flush_done,
  output logic              mc_req,
  output logic              mc_wb,
  output logic [ADDR_W-1:0] mc_base,
  output logic [ADDR_W-1:0] mc_high,
  input  logic [WIN_AW-1:0] mc_addr,
  input  logic              mc_we,
  input  logic [DATA_W-1:0] mc_din,
  output logic [DATA_W-1:0] mc_dout,
  input  logic              mc_done
);

  localparam int unsigned TAG_W  = calc_tag_w(ADDR_W, WIN_AW);
  localparam int unsigned IDX_W  = calc_idx_w(NUM_WIN);
  localparam int unsigned RAM_AW = IDX_W + WIN_AW;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WIN - 1);

  state_e             r_state;
  logic [NUM_WIN-1:0] r_valid;
  logic [NUM_WIN-1:0] r_dirty;
  logic [TAG_W-1:0]   r_tag [NUM_WIN];
  logic [IDX_W-1:0]   r_rr_ptr;
  logic [IDX_W-1:0]   r_victim;
  logic [IDX_W-1:0]   r_idx;
  logic [TAG_W-1:0]   r_miss_tag;
  logic               r_fl_pend;
  logic               r_mc_req;
  logic               r_mc_wb;
  logic [ADDR_W-1:0]  r_mc_base;
  logic [ADDR_W-1:0]  r_mc_high;
  logic               r_flush_done;

  state_e             w_state_nxt;
  logic [IDX_W-1:0]   w_victim_nxt;
  logic [IDX_W-1:0]   w_idx_nxt;
  logic [TAG_W-1:0]   w_miss_tag_nxt;
  logic               w_fl_pend_nxt;
  logic               w_flush_done_nxt;
  logic               w_upd;
  logic               w_clr_valid;
  logic               w_clr_dirty;
  logic               w_busy_nxt;
  logic               w_wb_nxt;
  logic [TAG_W-1:0]   w_mv_tag;

  logic [TAG_W-1:0]   w_tag;
  logic [WIN_AW-1:0]  w_off;
  logic               w_hit;
  logic [IDX_W-1:0]   w_hit_idx;
  logic               w_miss;
  logic               w_accept;
  logic               w_ram_b_we;

  assign w_tag = cpu_addr[ADDR_W-1:WIN_AW];
  assign w_off = cpu_addr[WIN_AW-1:0];

  // Tag compare across all windows; at most one can match.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int w = 0; w < int'(NUM_WIN); w++) begin
      if (r_valid[w] && (r_tag[w] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_idx = IDX_W'(w);
      end
    end
  end

  assign w_miss     = cpu_req & ~w_hit;
  assign cpu_stall  = cpu_req & ((r_state != ST_IDLE) | ~w_hit | r_fl_pend);
  assign w_accept   = cpu_req & ~cpu_stall;
  assign w_ram_b_we = mc_we & (r_state == ST_FILL);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic and bookkeeping strobes.
  always_comb begin
    w_state_nxt      = r_state;
    w_victim_nxt     = r_victim;
    w_idx_nxt        = r_idx;
    w_miss_tag_nxt   = r_miss_tag;
    w_fl_pend_nxt    = r_fl_pend | flush_req;
    w_flush_done_nxt = 1'b0;
    w_upd            = 1'b0;
    w_clr_valid      = 1'b0;
    w_clr_dirty      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_miss) begin
          w_miss_tag_nxt = w_tag;
          w_victim_nxt   = r_rr_ptr;
          w_state_nxt    = r_dirty[r_rr_ptr] ? ST_WB : ST_FILL;
        end else if (w_fl_pend_nxt) begin
          w_idx_nxt     = '0;
          w_fl_pend_nxt = 1'b0;
          w_state_nxt   = ST_FL_SCAN;
        end
      end
      ST_WB: begin
        if (mc_done) w_state_nxt = ST_FILL;
      end
      ST_FILL: begin
        if (mc_done) w_state_nxt = ST_UPDATE;
      end
      ST_UPDATE: begin
        w_upd       = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      ST_FL_SCAN: begin
        if (r_valid[r_idx] && r_dirty[r_idx]) begin
          w_victim_nxt = r_idx;
          w_state_nxt  = ST_FL_WB;
        end else begin
          w_clr_valid = 1'b1;
          if (r_idx == LAST_IDX) begin
            w_flush_done_nxt = 1'b1;
            w_state_nxt      = ST_IDLE;
          end else begin
            w_idx_nxt   = r_idx + IDX_W'(1);
            w_state_nxt = ST_FL_SCAN;
          end
        end
      end
      ST_FL_WB: begin
        if (mc_done) begin
          w_clr_valid = 1'b1;
          w_clr_dirty = 1'b1;
          if (r_idx == LAST_IDX) begin
            w_flush_done_nxt = 1'b1;
            w_state_nxt      = ST_IDLE;
          end else begin
            w_idx_nxt   = r_idx + IDX_W'(1);
            w_state_nxt = ST_FL_SCAN;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Controller-facing values for the state being entered.
  always_comb begin
    w_busy_nxt = (w_state_nxt == ST_WB) || (w_state_nxt == ST_FILL) || (w_state_nxt == ST_FL_WB);
    w_wb_nxt   = (w_state_nxt == ST_WB) || (w_state_nxt == ST_FL_WB);
    w_mv_tag   = (w_state_nxt == ST_FILL) ? w_miss_tag_nxt : r_tag[w_victim_nxt];
  end

  // Registered controller handshake, flush pulse and FSM scratch registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mc_req     <= 1'b0;
      r_mc_wb      <= 1'b0;
      r_mc_base    <= '0;
      r_mc_high    <= '0;
      r_flush_done <= 1'b0;
      r_victim     <= '0;
      r_idx        <= '0;
      r_miss_tag   <= '0;
      r_fl_pend    <= 1'b0;
    end else begin
      r_mc_req     <= w_busy_nxt;
      r_mc_wb      <= w_wb_nxt;
      r_flush_done <= w_flush_done_nxt;
      r_victim     <= w_victim_nxt;
      r_idx        <= w_idx_nxt;
      r_miss_tag   <= w_miss_tag_nxt;
      r_fl_pend    <= w_fl_pend_nxt;
      if (w_busy_nxt) begin
        r_mc_base <= {w_mv_tag, {WIN_AW{1'b0}}};
        r_mc_high <= {w_mv_tag, {WIN_AW{1'b1}}};
      end
    end
  end

  // Per-window valid/dirty/tag state and the round-robin pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid  <= '0;
      r_dirty  <= '0;
      r_rr_ptr <= '0;
      for (int w = 0; w < int'(NUM_WIN); w++) r_tag[w] <= '0;
    end else begin
      if (w_upd) begin
        r_tag[r_victim]   <= r_miss_tag;
        r_valid[r_victim] <= 1'b1;
        r_dirty[r_victim] <= 1'b0;
        r_rr_ptr          <= (r_rr_ptr == LAST_IDX) ? '0 : r_rr_ptr + IDX_W'(1);
      end
      if (w_clr_valid) r_valid[r_idx] <= 1'b0;
      if (w_clr_dirty) r_dirty[r_idx] <= 1'b0;
      if (w_accept && cpu_we) r_dirty[w_hit_idx] <= 1'b1;
    end
  end

  dmem_win_ram #(
    .DATA_W (DATA_W),
    .AW     (RAM_AW)
  ) u_ram (
    .clk       (clk),
    .rst       (rst),
    .i_a_en    (w_accept),
    .i_a_we    (cpu_we),
    .i_a_addr  ({w_hit_idx, w_off}),
    .i_a_wdata (cpu_wdata),
    .o_a_rdata (cpu_rdata),
    .i_b_we    (w_ram_b_we),
    .i_b_addr  ({r_victim, mc_addr}),
    .i_b_wdata (mc_din),
    .o_b_rdata (mc_dout)
  );

  assign mc_req     = r_mc_req;
  assign mc_wb      = r_mc_wb;
  assign mc_base    = r_mc_base;
  assign mc_high    = r_mc_high;
  assign flush_done = r_flush_done;

endmodule

// File: tb/tb_dmem_window_cache.sv
// Directed bench for dmem_window_cache with hand-computed expectations.
module tb_dmem_window_cache;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned WIN_AW  = 10;
  localparam int unsigned NUM_WIN = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;
  logic              flush_req;
  logic              flush_done;
  logic              mc_req;
  logic              mc_wb;
  logic [ADDR_W-1:0] mc_base;
  logic [ADDR_W-1:0] mc_high;
  logic [WIN_AW-1:0] mc_addr;
  logic              mc_we;
  logic [DATA_W-1:0] mc_din;
  logic [DATA_W-1:0] mc_dout;
  logic              mc_done;

  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_fail = 0;
  int   n_wb_starts = 0;
  int   wb_base_cnt;
  logic mc_req_q = 1'b0;

  always #5 clk = ~clk;

  dmem_window_cache #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .WIN_AW  (WIN_AW),
    .NUM_WIN (NUM_WIN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_stall  (cpu_stall),
    .flush_req  (flush_req),
    .flush_done (flush_done),
    .mc_req     (mc_req),
    .mc_wb      (mc_wb),
    .mc_base    (mc_base),
    .mc_high    (mc_high),
    .mc_addr    (mc_addr),
    .mc_we      (mc_we),
    .mc_din     (mc_din),
    .mc_dout    (mc_dout),
    .mc_done    (mc_done)
  );

  // Count write-back operations started (rising mc_req with mc_wb set).
  always @(posedge clk) begin
    if (mc_req && mc_wb && !mc_req_q) n_wb_starts <= n_wb_starts + 1;
    mc_req_q <= mc_req;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    flush_req = 1'b0; mc_addr = '0; mc_we = 1'b0; mc_din = '0; mc_done = 1'b0;
    tick(); tick();
    chk("rst_mc_req", mc_req, 0);
    chk("rst_mc_wb", mc_wb, 0);
    chk("rst_flush_done", flush_done, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_mc_base", mc_base, 0);
    chk("rst_mc_high", mc_high, 0);
    rst = 1'b1;
    tick();
    chk("idle_stall", cpu_stall, 0);

    // Cold read of 0x404: fill window 0 (rr_ptr 0).
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0404;
    #1 chk("cold_stall", cpu_stall, 1);
    tick();
    chk("cold_mc_req", mc_req, 1);
    chk("cold_mc_wb", mc_wb, 0);
    chk("cold_base", mc_base, 32'h400);
    chk("cold_high", mc_high, 32'h7FF);
    mc_we = 1'b1; mc_addr = 10'd4; mc_din = 32'hDEAD_BEEF;
    tick();
    mc_we = 1'b0; mc_done = 1'b1;
    tick();
    mc_done = 1'b0;
    chk("cold_req_drop", mc_req, 0);
    chk("cold_update_stall", cpu_stall, 1);
    tick();
    chk("cold_hit_stall", cpu_stall, 0);
    tick();
    chk("cold_rdata", cpu_rdata, 32'hDEAD_BEEF);
    cpu_req = 1'b0;
    tick();
    chk("cold_rdata_hold", cpu_rdata, 32'hDEAD_BEEF);

    // Hit write 0x1234 to 0x404, then read it back.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h404; cpu_wdata = 32'h1234;
    #1 chk("wr_hit_stall", cpu_stall, 0);
    tick();
    cpu_we = 1'b0;
    tick();
    chk("wr_readback", cpu_rdata, 32'h1234);
    cpu_req = 1'b0;

    // Miss 0x800: victim window 1 is clean, no write-back.
    cpu_req = 1'b1; cpu_addr = 32'h800;
    #1 chk("m800_stall", cpu_stall, 1);
    tick();
    chk("m800_req", mc_req, 1);
    chk("m800_wb", mc_wb, 0);
    chk("m800_base", mc_base, 32'h800);
    chk("m800_high", mc_high, 32'hBFF);
    mc_we = 1'b1; mc_addr = 10'd0; mc_din = 32'hA5A5_0800;
    tick();
    mc_we = 1'b0;
    chk("m800_wb_hold", mc_wb, 0);
    mc_done = 1'b1;
    tick();
    mc_done = 1'b0;
    tick();
    chk("m800_hit_stall", cpu_stall, 0);
    tick();
    chk("m800_rdata", cpu_rdata, 32'hA5A5_0800);
    cpu_req = 1'b0;

    // Miss 0xC00: victim window 0 is dirty -> write-back then fill.
    cpu_req = 1'b1; cpu_addr = 32'hC00;
    #1 chk("mC00_stall", cpu_stall, 1);
    tick();
    chk("wb_req", mc_req, 1);
    chk("wb_wb", mc_wb, 1);
    chk("wb_base", mc_base, 32'h400);
    chk("wb_high", mc_high, 32'h7FF);
    mc_addr = 10'd4;
    tick();
    chk("wb_dout", mc_dout, 32'h1234);
    mc_done = 1'b1;
    tick();
    mc_done = 1'b0;
    chk("mC00_fill_req", mc_req, 1);
    chk("mC00_fill_wb", mc_wb, 0);
    chk("mC00_base", mc_base, 32'hC00);
    chk("mC00_high", mc_high, 32'hFFF);
    mc_we = 1'b1; mc_addr = 10'd0; mc_din = 32'h0C0C_0C0C;
    tick();
    mc_we = 1'b0; mc_done = 1'b1;
    tick();
    mc_done = 1'b0;
    tick();
    chk("mC00_hit_stall", cpu_stall, 0);
    tick();
    chk("mC00_rdata", cpu_rdata, 32'h0C0C_0C0C);

    // 0x800 still resident in window 1; dirty it at 0x805.
    cpu_addr = 32'h800;
    #1 chk("w1_hit_stall", cpu_stall, 0);
    tick();
    chk("w1_rdata", cpu_rdata, 32'hA5A5_0800);
    cpu_we = 1'b1; cpu_addr = 32'h805; cpu_wdata = 32'h55;
    #1 chk("w1_wr_stall", cpu_stall, 0);
    tick();
    cpu_req = 1'b0; cpu_we = 1'b0;

    // Flush: window 0 clean, window 1 dirty -> exactly one write-back.
    wb_base_cnt = n_wb_starts;
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    for (int i = 0; i < 8 && !mc_req; i++) tick();
    chk("fl_wb_req", mc_req, 1);
    chk("fl_wb_wb", mc_wb, 1);
    chk("fl_wb_base", mc_base, 32'h800);
    chk("fl_wb_high", mc_high, 32'hBFF);
    mc_addr = 10'd5;
    tick();
    chk("fl_wb_dout", mc_dout, 32'h55);
    mc_done = 1'b1;
    tick();
    mc_done = 1'b0;
    chk("fl_done_pulse", flush_done, 1);
    chk("fl_req_drop", mc_req, 0);
    tick();
    chk("fl_done_clear", flush_done, 0);
    chk("fl_wb_count", 64'(n_wb_starts - wb_base_cnt), 1);
    cpu_req = 1'b1; cpu_addr = 32'h805;
    #1 chk("fl_inval_w1", cpu_stall, 1);
    cpu_addr = 32'hC00;
    #1 chk("fl_inval_w0", cpu_stall, 1);
    cpu_req = 1'b0;

    // Simultaneous miss and flush: fill first (victim 1), then the flush.
    wb_base_cnt = n_wb_starts;
    cpu_req = 1'b1; cpu_addr = 32'h404; flush_req = 1'b1;
    #1 chk("sim_stall", cpu_stall, 1);
    tick();
    flush_req = 1'b0;
    chk("sim_fill_req", mc_req, 1);
    chk("sim_fill_wb", mc_wb, 0);
    chk("sim_fill_base", mc_base, 32'h400);
    mc_we = 1'b1; mc_addr = 10'd4; mc_din = 32'h7777;
    tick();
    mc_we = 1'b0; mc_done = 1'b1;
    tick();
    mc_done = 1'b0;
    tick();
    chk("sim_pend_stall", cpu_stall, 1);
    tick();
    chk("sim_scan0_stall", cpu_stall, 1);
    tick();
    chk("sim_scan1_stall", cpu_stall, 1);
    tick();
    chk("sim_flush_done", flush_done, 1);
    chk("sim_no_wb", 64'(n_wb_starts - wb_base_cnt), 0);
    chk("sim_post_miss", cpu_stall, 1);
    tick();
    chk("re_fill_req", mc_req, 1);
    chk("re_fill_base", mc_base, 32'h400);

    // Reset in the middle of a fill aborts it; the same read misses again.
    #2 rst = 1'b0;
    #1 chk("rst_mid_req", mc_req, 0);
    chk("rst_mid_base", mc_base, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    #1 chk("post_rst_miss", cpu_stall, 1);
    tick();
    chk("post_rst_req", mc_req, 1);
    chk("post_rst_wb", mc_wb, 0);
    chk("post_rst_base", mc_base, 32'h400);
    mc_we = 1'b1; mc_addr = 10'd4; mc_din = 32'h0BAD_F00D;
    tick();
    mc_we = 1'b0; mc_done = 1'b1;
    tick();
    mc_done = 1'b0;
    tick();
    chk("post_rst_hit", cpu_stall, 0);
    tick();
    chk("post_rst_rdata", cpu_rdata, 32'h0BAD_F00D);
    cpu_req = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
